// File: rtl/usb_tx_sequencer_pkg.sv
// Shared types and constants for the USB full-speed transmit sequencer.
// Holds the FSM state encoding, the raw SYNC byte and the default EOP SE0 length.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_EOP_SE0 = 3'd4,
        ST_EOP_J   = 3'd5
    } state_t;

    // Raw SYNC field, sent LSB first: seven zeros then a one.
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    localparam int SE0_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/usb_tx_sequencer_if.sv
// Byte handshake, bit-stuffer/encoder side-band and line-drive signals of the sequencer.
// The master side is the packet source plus encoder; the slave side is the sequencer.
interface usb_tx_sequencer_if;
    logic       start;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       stall;
    logic       enc_bit;
    logic       enc_sending;
    logic       bit_out;
    logic       seq_sending;
    logic       dp;
    logic       dm;
    logic       busy;
    logic       done;
    logic       underrun;

    modport master (
        output start, tx_byte, tx_valid, tx_last, stall, enc_bit, enc_sending,
        input  tx_ready, bit_out, seq_sending, dp, dm, busy, done, underrun
    );

    modport slave (
        input  start, tx_byte, tx_valid, tx_last, stall, enc_bit, enc_sending,
        output tx_ready, bit_out, seq_sending, dp, dm, busy, done, underrun
    );
endinterface

// File: rtl/usb_tx_shifter.sv
// Payload shift register, 3-bit bit counter and last-byte flag.
// Everything advances only on a non-stalled sending cycle, so a stuffed bit freezes the stream.
module usb_tx_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_sending,
    input  logic       i_stall,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_last,
    output logic [2:0] o_cnt,
    output logic       o_bit0,
    output logic       o_last
);

    logic [7:0] r_shift;
    logic [2:0] r_cnt;
    logic       r_last;
    logic       w_advance;

    assign w_advance = i_sending && !i_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 8'h00;
            r_cnt   <= 3'd0;
            r_last  <= 1'b0;
        end else if (i_clear) begin
            r_shift <= 8'h00;
            r_cnt   <= 3'd0;
            r_last  <= 1'b0;
        end else if (w_advance) begin
            r_cnt <= r_cnt + 3'd1;
            // A load only ever coincides with the count-7 advance that ends a byte.
            if (i_load) begin
                r_shift <= i_byte;
                r_last  <= i_last;
            end else begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_bit0 = r_shift[0];
    assign o_last = r_last;

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB full-speed packet sequencer: SYNC, LSB-first payload, encoder drain, then SE0/J EOP.
// Feeds raw bits to the bit stuffer and muxes the line between encoder output and EOP/idle.
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int SE0_CYCLES = SE0_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    usb_tx_sequencer_if.slave  bus
);

    localparam int SE0_W = (SE0_CYCLES > 1) ? $clog2(SE0_CYCLES) : 1;
    localparam logic [SE0_W-1:0] SE0_LAST = SE0_W'(SE0_CYCLES - 1);

    state_t           r_state;
    logic [SE0_W-1:0] r_se0_cnt;
    logic             r_busy;
    logic             r_done;

    logic [2:0] w_cnt;
    logic       w_bit0;
    logic       w_last;
    logic       w_sending;
    logic       w_byte_end;
    logic       w_ready;
    logic       w_load;
    logic       w_clear;

    assign w_sending  = (r_state == ST_SYNC) || (r_state == ST_DATA);
    assign w_byte_end = w_sending && !bus.stall && (w_cnt == 3'd7);
    // After SYNC a byte is always wanted; after a payload byte only if it was not the last.
    assign w_ready    = w_byte_end && ((r_state == ST_SYNC) || !w_last);
    assign w_load     = w_ready && bus.tx_valid;
    assign w_clear    = (r_state == ST_IDLE) && bus.start;

    usb_tx_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_sending (w_sending),
        .i_stall   (bus.stall),
        .i_load    (w_load),
        .i_byte    (bus.tx_byte),
        .i_last    (bus.tx_last),
        .o_cnt     (w_cnt),
        .o_bit0    (w_bit0),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_se0_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_SYNC;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    // Last byte finished or underrun both fall through to the drain.
                    if (w_byte_end) begin
                        r_state <= w_load ? ST_DATA : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.enc_sending) begin
                        r_state   <= ST_EOP_SE0;
                        r_se0_cnt <= '0;
                    end
                end
                ST_EOP_SE0: begin
                    if (r_se0_cnt == SE0_LAST) begin
                        r_state <= ST_EOP_J;
                        r_done  <= 1'b1;
                    end else begin
                        r_se0_cnt <= r_se0_cnt + SE0_W'(1);
                    end
                end
                ST_EOP_J: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_ready    = w_ready;
    assign bus.underrun    = w_ready && !bus.tx_valid;
    assign bus.seq_sending = w_sending;
    assign bus.bit_out     = (r_state == ST_SYNC) ? SYNC_PATTERN[w_cnt] :
                             (r_state == ST_DATA) ? w_bit0 : 1'b0;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

    // EOP states own the line; otherwise the encoder drives it, or J when it is quiet.
    always_comb begin
        bus.dp = 1'b1;
        bus.dm = 1'b0;
        if (r_state == ST_EOP_SE0) begin
            bus.dp = 1'b0;
            bus.dm = 1'b0;
        end else if (r_state == ST_EOP_J) begin
            bus.dp = 1'b1;
            bus.dm = 1'b0;
        end else if (bus.enc_sending) begin
            bus.dp = bus.enc_bit;
            bus.dm = ~bus.enc_bit;
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench for usb_tx_sequencer: directed and randomized packets against
// a bit-stream reference model (SYNC + LSB-first bytes, drain, SE0 run, J).
module tb_usb_tx_sequencer;

    localparam int SE0 = 2;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic [7:0] pkt [$];

    usb_tx_sequencer_if bus ();

    usb_tx_sequencer #(.SE0_CYCLES(SE0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk1({tag, " busy"},     bus.busy, 1'b0);
        chk1({tag, " tx_ready"}, bus.tx_ready, 1'b0);
        chk1({tag, " bit_out"},  bus.bit_out, 1'b0);
        chk1({tag, " seq"},      bus.seq_sending, 1'b0);
        chk1({tag, " done"},     bus.done, 1'b0);
        chk1({tag, " underrun"}, bus.underrun, 1'b0);
        chk1({tag, " dp"},       bus.dp, 1'b1);
        chk1({tag, " dm"},       bus.dm, 1'b0);
    endtask

    // Called at posedge+1 with the DUT idle. u = index of the byte withheld (>= size: none),
    // tail = encoder cycles after the last raw bit, abort_k = bit index where reset hits (-1: none).
    task automatic run_packet(input int u, input int tail, input int stall_pct,
                              input int stall_k, input int stall_len,
                              input bit start_se0, input int abort_k);
        int n, m, total, k, phase, drain_j, se0_j, next_byte, forced_left;
        int stall_cnt, obs_ready, obs_seq, cyc;
        bit stream[$];
        bit st, enc, eb, adv, e_ready, e_under, e_bit, e_dp, e_dm, valid, aborted;
        n = pkt.size();
        m = (u < n) ? u : n;
        total = 8 * (m + 1);
        for (int i = 0; i < 7; i++) stream.push_back(1'b0);
        stream.push_back(1'b1);
        for (int b = 0; b < m; b++)
            for (int i = 0; i < 8; i++) stream.push_back(pkt[b][i]);
        k = 0; phase = 0; drain_j = 0; se0_j = 0; next_byte = 0;
        forced_left = stall_len; stall_cnt = 0; obs_ready = 0; obs_seq = 0; cyc = 0;
        aborted = 1'b0;

        bus.start = 1'b1; bus.stall = 1'b0; bus.tx_valid = 1'b0; bus.tx_last = 1'b0;
        bus.enc_sending = 1'b0; bus.enc_bit = 1'b0;
        @(negedge clk);
        chk1("start_cycle busy", bus.busy, 1'b0);
        chk1("start_cycle dp", bus.dp, 1'b1);
        @(posedge clk); #1;

        while (phase < 4) begin
            if (phase == 0 && k == abort_k) begin
                aborted = 1'b1;
                break;
            end
            st = 1'b0;
            if (phase == 0 && k == stall_k && forced_left > 0) begin
                st = 1'b1;
                forced_left--;
            end else if (int'($urandom_range(99)) < stall_pct) begin
                st = 1'b1;
            end
            valid = (next_byte < n) && (next_byte != u);
            enc   = (phase == 1) ? (drain_j < tail) : ($urandom_range(1) == 1);
            eb    = 1'($urandom_range(1));
            bus.stall       = st;
            bus.tx_valid    = valid;
            bus.tx_byte     = (next_byte < n) ? pkt[next_byte] : 8'($urandom);
            bus.tx_last     = (next_byte == n - 1);
            bus.enc_sending = enc;
            bus.enc_bit     = eb;
            bus.start       = (start_se0 && phase == 2) || ($urandom_range(3) == 0);
            @(negedge clk);

            adv     = (phase == 0) && !st;
            e_ready = adv && (k % 8 == 7) && (k / 8 < n);
            e_under = e_ready && (k / 8 == u);
            e_bit   = (phase == 0) ? stream[k] : 1'b0;
            if (phase == 2)      begin e_dp = 1'b0; e_dm = 1'b0; end
            else if (phase == 3) begin e_dp = 1'b1; e_dm = 1'b0; end
            else if (enc)        begin e_dp = eb;   e_dm = ~eb;  end
            else                 begin e_dp = 1'b1; e_dm = 1'b0; end

            chk1($sformatf("c%0d k%0d tx_ready", cyc, k), bus.tx_ready, e_ready);
            chk1($sformatf("c%0d k%0d underrun", cyc, k), bus.underrun, e_under);
            chk1($sformatf("c%0d k%0d bit_out", cyc, k), bus.bit_out, e_bit);
            chk1($sformatf("c%0d k%0d seq_sending", cyc, k), bus.seq_sending, phase == 0);
            chk1($sformatf("c%0d ph%0d dp", cyc, phase), bus.dp, e_dp);
            chk1($sformatf("c%0d ph%0d dm", cyc, phase), bus.dm, e_dm);
            chk1($sformatf("c%0d ph%0d busy", cyc, phase), bus.busy, 1'b1);
            chk1($sformatf("c%0d ph%0d done", cyc, phase), bus.done, phase == 3);
            if (bus.tx_ready) obs_ready++;
            if (bus.seq_sending) obs_seq++;
            if (e_ready && valid) next_byte++;
            if (phase == 0 && st) stall_cnt++;

            case (phase)
                0: if (adv) begin
                       k++;
                       if (k == total) phase = 1;
                   end
                1: if (!enc) phase = 2; else drain_j++;
                2: begin
                       se0_j++;
                       if (se0_j == SE0) phase = 3;
                   end
                default: phase = 4;
            endcase
            cyc++;
            @(posedge clk); #1;
        end

        if (aborted) begin
            rst_n = 1'b0;
            bus.start = 1'b0; bus.stall = 1'b0; bus.tx_valid = 1'b0;
            bus.enc_sending = 1'b0;
            #1;
            check_idle_outputs($sformatf("abort k%0d", k));
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            chk16("packet ready pulses", 16'(obs_ready), 16'((u < n) ? u + 1 : n));
            chk16("packet seq cycles", 16'(obs_seq), 16'(total + stall_cnt));
        end

        for (int i = 0; i < 3; i++) begin
            bus.start = 1'b0; bus.enc_sending = 1'b0; bus.tx_valid = 1'b0;
            bus.stall = 1'($urandom_range(1));
            @(negedge clk);
            check_idle_outputs($sformatf("post idle %0d", i));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.tx_byte = 8'h00; bus.tx_valid = 1'b0; bus.tx_last = 1'b0;
        bus.stall = 1'b0; bus.enc_bit = 1'b0; bus.enc_sending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single byte A5, no stalls, encoder quiet at drain.
        pkt = '{8'hA5};
        run_packet(99, 0, 0, -1, 0, 1'b0, -1);

        // Three bytes, exactly three accepts.
        pkt = '{8'h01, 8'hFF, 8'h00};
        run_packet(99, 0, 0, -1, 0, 1'b0, -1);

        // Two-cycle stall at DATA count 3.
        pkt = '{8'hA5};
        run_packet(99, 0, 0, 11, 2, 1'b0, -1);

        // Stall sitting on SYNC count 7 delays the accept.
        pkt = '{8'h3C, 8'hC3};
        run_packet(99, 0, 0, 7, 3, 1'b0, -1);

        // Underrun at the end of SYNC.
        pkt = '{8'h12, 8'h34};
        run_packet(0, 0, 0, -1, 0, 1'b0, -1);

        // Encoder keeps sending 5 cycles after the last raw bit.
        pkt = '{8'h5A};
        run_packet(99, 5, 0, -1, 0, 1'b0, -1);

        // Start held during EOP SE0 is ignored.
        pkt = '{8'h81};
        run_packet(99, 1, 0, -1, 0, 1'b1, -1);

        // Reset in the middle of DATA, then a clean packet.
        pkt = '{8'hF0, 8'h0F};
        run_packet(99, 0, 0, -1, 0, 1'b0, 12);
        pkt = '{8'hE7};
        run_packet(99, 0, 0, -1, 0, 1'b0, -1);

        for (int p = 0; p < 24; p++) begin
            n = $urandom_range(1, 4);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            run_packet(($urandom_range(3) == 0) ? int'($urandom_range(0, n - 1)) : 99,
                       $urandom_range(0, 5), $urandom_range(0, 40),
                       $urandom_range(0, 8 * n + 7), $urandom_range(0, 3),
                       1'($urandom_range(1)),
                       ($urandom_range(7) == 0) ? int'($urandom_range(0, 8 * n + 7)) : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_tx_sequencer.md
USB_TX_SEQUENCER -- requirements
Module: usb_tx_sequencer

Interface
REQ-001 Parameter: SE0_CYCLES, default 2, EOP SE0 length in clocks.
REQ-002 clock  input  1  single system clock, all state on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to send a packet; honoured only in IDLE.
REQ-005 tx_byte  input  8  payload byte, serialized LSB first.
REQ-006 tx_valid  input  1  tx_byte/tx_last valid.
REQ-007 tx_last  input  1  marks final payload byte.
REQ-008 tx_ready  output  1  byte accepted this cycle when tx_valid && tx_ready.
REQ-009 stall  input  1  downstream bit stuffer inserting a stuffed bit; sequencer holds.
REQ-010 enc_bit  input  1  NRZI-encoded bit returned from encoder.
REQ-011 enc_sending  input  1  encoder still emitting bits.
REQ-012 bit_out  output  1  raw (pre-stuff, pre-NRZI) bit to bit stuffer.
REQ-013 seq_sending  output  1  bit_out valid this cycle.
REQ-014 dp, dm  output  1 each  full-speed line drive.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse on return to IDLE after EOP.
REQ-017 underrun  output  1  one-cycle pulse when a byte was required but tx_valid was low.

Function
REQ-018 States SHALL be IDLE, SYNC, DATA, DRAIN, EOP_SE0, EOP_J.
REQ-019 IDLE: start=1 -> SYNC with bit counter 0; start in any other state SHALL be ignored.
REQ-020 SYNC: seq_sending=1; bit_out = 0 for counts 0-6, 1 for count 7 (raw 8'h80 LSB first).
REQ-021 Bit counter (3 bits, wraps 7->0) SHALL advance only when seq_sending && !stall; while stall=1, bit_out, counter and shift register hold.
REQ-022 tx_ready SHALL be 1 only on a non-stalled count-7 cycle of SYNC, or of DATA when the current byte is not last; it is 0 otherwise.
REQ-023 Accepted byte loads the shift register and tx_last into a last flag; next cycle enters/stays DATA with bit_out = tx_byte[0].
REQ-024 DATA: bit_out = shift register bit 0; shift right on each advance.
REQ-025 tx_ready=1 && tx_valid=0: underrun pulses, go to DRAIN (packet truncated).
REQ-026 Count 7 of a last byte, not stalled: -> DRAIN; seq_sending=0 from DRAIN onward.
REQ-027 DRAIN: stay while enc_sending=1; enc_sending=0 -> EOP_SE0.
REQ-028 EOP_SE0: dp=0, dm=0 for exactly SE0_CYCLES clocks, then EOP_J.
REQ-029 EOP_J: dp=1, dm=0 for one clock; -> IDLE with done=1 in that EOP_J cycle.
REQ-030 Line mux otherwise: enc_sending=1 -> dp=enc_bit, dm=~enc_bit; else dp=1, dm=0 (J idle).
REQ-031 Single-byte packet (tx_last on first byte) SHALL be legal: SYNC, 8 data bits, DRAIN.
REQ-032 stall during count 7 SHALL delay tx_ready/transition until the first non-stalled count-7 cycle.

Reset
REQ-033 reset_n=0 SHALL force IDLE immediately, counter 0, shift register 0, last flag 0.
REQ-034 Reset outputs: tx_ready=0, bit_out=0, seq_sending=0, busy=0, done=0, underrun=0, dp=1, dm=0.
REQ-035 Reset mid-packet SHALL abandon the packet without EOP; no done or underrun pulse.

Structure
REQ-036 Package usb_tx_pkg SHALL hold the state enum, SYNC_PATTERN = 8'h80 and default SE0_CYCLES.
REQ-037 One sub-module, usb_tx_shifter (shift register, bit counter, last flag, stall hold), is natural; FSM and line mux stay in the top.

Verification
REQ-038 start, bytes 8'hA5 (last), no stall -> bit_out 0000000 1 then 1,0,1,0,0,1,0,1; tx_ready once at SYNC count 7; done after 2 SE0 + 1 J.
REQ-039 Three bytes 8'h01,8'hFF,8'h00(last) valid -> exactly 3 tx_ready pulses, 32 seq_sending cycles total.
REQ-040 stall=1 for 2 cycles at DATA count 3 -> bit_out held 3 cycles, packet 2 cycles longer, data unchanged.
REQ-041 tx_valid=0 at SYNC count 7 -> underrun pulse, DRAIN, then SE0,SE0,J, done.
REQ-042 enc_sending held 5 cycles after last bit -> dp/dm follow enc_bit, SE0 starts cycle after enc_sending falls.
REQ-043 reset_n low during DATA, start asserted during EOP_SE0 -> IDLE/J immediately; start ignored, no second packet.
